// File: rtl/lbp_if.sv
// Bus bundle for the LBP engine: frame control, image-memory read port,
// result-memory write port and status flags.
interface lbp_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14
) ();
    logic              start;
    logic [PIX_W-1:0]  thr;
    logic              write_border;
    logic              gray_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [PIX_W-1:0]  gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              busy;
    logic              finish;

    // Controller / memory side
    modport master (
        output start, thr, write_border, gray_ready, gray_data,
        input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, busy, finish
    );

    // Engine side
    modport slave (
        input  start, thr, write_border, gray_ready, gray_data,
        output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, busy, finish
    );
endinterface

// File: rtl/lbp_engine.sv
// Local-binary-pattern engine: raster-scans a W x H image from a
// synchronous-read memory, builds an 8-bit LBP code per interior pixel
// and writes it (plus optional zero codes on the border) to a result memory.
module lbp_engine #(
    parameter int W_LOG2 = 7,
    parameter int H_LOG2 = 7,
    parameter int PIX_W  = 8
) (
    input  logic  clk,
    input  logic  reset,
    lbp_if.slave  bus
);
    localparam int ADDR_W = W_LOG2 + H_LOG2;
    localparam logic [W_LOG2-1:0] XMAX  = '1;
    localparam logic [H_LOG2-1:0] YMAX  = '1;
    localparam logic [W_LOG2-1:0] X_ONE = 1;
    localparam logic [H_LOG2-1:0] Y_ONE = 1;

    typedef enum logic [2:0] {IDLE, WAIT_RDY, PIXEL, FETCH, LAST, WRITE, DONE} state_t;

    state_t             state_reg;
    logic [W_LOG2-1:0]  x_reg;
    logic [H_LOG2-1:0]  y_reg;
    logic [3:0]         fcnt_reg;
    logic [PIX_W-1:0]   center_reg;
    logic [PIX_W-1:0]   thr_reg;
    logic               wb_reg;
    logic [7:0]         code_reg;
    logic               gray_req_reg;
    logic [ADDR_W-1:0]  gray_addr_reg;
    logic               lbp_valid_reg;
    logic [ADDR_W-1:0]  lbp_addr_reg;
    logic [7:0]         lbp_data_reg;
    logic               busy_reg;
    logic               finish_reg;

    logic               is_border;
    logic               is_last;
    logic [3:0]         sel_idx;
    logic [2:0]         bit_idx;
    logic [W_LOG2-1:0]  nb_x;
    logic [H_LOG2-1:0]  nb_y;
    logic               ge;

    assign is_border = (x_reg == '0) || (x_reg == XMAX) || (y_reg == '0) || (y_reg == YMAX);
    assign is_last   = (x_reg == XMAX) && (y_reg == YMAX);
    // Index of the address to present next: centre when entering FETCH,
    // otherwise the one after the address currently on the bus.
    assign sel_idx   = (state_reg == FETCH) ? fcnt_reg + 4'd1 : 4'd0;
    // Neighbour data lags its request by one cycle and the centre by two.
    assign bit_idx   = 3'(fcnt_reg - 4'd2);
    // Widened compare so that C + thr past full scale can never wrap.
    assign ge = {1'b0, bus.gray_data} >= ({1'b0, center_reg} + {1'b0, thr_reg});

    // Neighbour coordinate for the fetch order C, lu, up, ru, l, r, dl, dn, dr
    always_comb begin
        nb_x = x_reg;
        nb_y = y_reg;
        case (sel_idx)
            4'd1: begin nb_x = x_reg - X_ONE; nb_y = y_reg - Y_ONE; end
            4'd2: begin nb_y = y_reg - Y_ONE; end
            4'd3: begin nb_x = x_reg + X_ONE; nb_y = y_reg - Y_ONE; end
            4'd4: begin nb_x = x_reg - X_ONE; end
            4'd5: begin nb_x = x_reg + X_ONE; end
            4'd6: begin nb_x = x_reg - X_ONE; nb_y = y_reg + Y_ONE; end
            4'd7: begin nb_y = y_reg + Y_ONE; end
            4'd8: begin nb_x = x_reg + X_ONE; nb_y = y_reg + Y_ONE; end
            default: ;
        endcase
    end

    // Frame FSM with all bus outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            x_reg         <= '0;
            y_reg         <= '0;
            fcnt_reg      <= '0;
            center_reg    <= '0;
            thr_reg       <= '0;
            wb_reg        <= 1'b0;
            code_reg      <= '0;
            gray_req_reg  <= 1'b0;
            gray_addr_reg <= '0;
            lbp_valid_reg <= 1'b0;
            lbp_addr_reg  <= '0;
            lbp_data_reg  <= '0;
            busy_reg      <= 1'b0;
            finish_reg    <= 1'b0;
        end else begin
            lbp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        thr_reg    <= bus.thr;
                        wb_reg     <= bus.write_border;
                        finish_reg <= 1'b0;
                        busy_reg   <= 1'b1;
                        x_reg      <= '0;
                        y_reg      <= '0;
                        state_reg  <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (bus.gray_ready)
                        state_reg <= PIXEL;
                end
                // WRITE shows the previous interior result on the bus while
                // already handling the next pixel, so it shares PIXEL's logic.
                PIXEL, WRITE: begin
                    code_reg <= '0;
                    if (is_border) begin
                        if (wb_reg) begin
                            lbp_valid_reg <= 1'b1;
                            lbp_addr_reg  <= {y_reg, x_reg};
                            lbp_data_reg  <= '0;
                        end
                        if (x_reg == XMAX) begin
                            x_reg <= '0;
                            y_reg <= y_reg + Y_ONE;
                        end else begin
                            x_reg <= x_reg + X_ONE;
                        end
                        state_reg <= is_last ? DONE : PIXEL;
                    end else begin
                        gray_req_reg  <= 1'b1;
                        gray_addr_reg <= {nb_y, nb_x};
                        fcnt_reg      <= '0;
                        state_reg     <= FETCH;
                    end
                end
                FETCH: begin
                    if (fcnt_reg == 4'd1)
                        center_reg <= bus.gray_data;
                    if (fcnt_reg >= 4'd2)
                        code_reg[bit_idx] <= ge;
                    if (fcnt_reg == 4'd8) begin
                        gray_req_reg <= 1'b0;
                        state_reg    <= LAST;
                    end else begin
                        gray_addr_reg <= {nb_y, nb_x};
                        fcnt_reg      <= fcnt_reg + 4'd1;
                    end
                end
                LAST: begin
                    lbp_valid_reg <= 1'b1;
                    lbp_addr_reg  <= {y_reg, x_reg};
                    lbp_data_reg  <= {ge, code_reg[6:0]};
                    if (x_reg == XMAX) begin
                        x_reg <= '0;
                        y_reg <= y_reg + Y_ONE;
                    end else begin
                        x_reg <= x_reg + X_ONE;
                    end
                    state_reg <= WRITE;
                end
                DONE: begin
                    busy_reg   <= 1'b0;
                    finish_reg <= 1'b1;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.gray_req  = gray_req_reg;
    assign bus.gray_addr = gray_addr_reg;
    assign bus.lbp_valid = lbp_valid_reg;
    assign bus.lbp_addr  = lbp_addr_reg;
    assign bus.lbp_data  = lbp_data_reg;
    assign bus.busy      = busy_reg;
    assign bus.finish    = finish_reg;
endmodule

// File: tb/tb_lbp_engine.sv
// Scoreboard bench for lbp_engine on a 4x4 image with hand-computed codes.
module tb_lbp_engine;
    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    logic [7:0] mem [16];

    lbp_if #(.PIX_W(8), .ADDR_W(4)) bus ();

    lbp_engine #(.W_LOG2(2), .H_LOG2(2), .PIX_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read image memory: data appears the cycle after the request
    always @(posedge clk)
        if (bus.gray_req) bus.gray_data <= mem[bus.gray_addr];

    // Monitor: every result write is matched against the scoreboard head
    always @(negedge clk) begin
        if (!reset && bus.lbp_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected: got addr=%0d data=%02h, required no write",
                         bus.lbp_addr, bus.lbp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.addr !== bus.lbp_addr || e.data !== bus.lbp_data) begin
                    bad++;
                    $display("FAIL write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             bus.lbp_addr, bus.lbp_data, e.addr, e.data);
                end else begin
                    $display("write ok: addr=%0d data=%02h", bus.lbp_addr, bus.lbp_data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("check ok: %s = %0d", name, act);
        end
    endtask

    task automatic push(input int a, input int d);
        exp_t e;
        e.addr = 4'(a);
        e.data = 8'(d);
        exp_q.push_back(e);
    endtask

    task automatic push_int(input int d5, input int d6, input int d9, input int d10);
        push(5, d5); push(6, d6); push(9, d9); push(10, d10);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_gray_req"},  int'(bus.gray_req),  0);
        check({tag, "_gray_addr"}, int'(bus.gray_addr), 0);
        check({tag, "_lbp_valid"}, int'(bus.lbp_valid), 0);
        check({tag, "_lbp_addr"},  int'(bus.lbp_addr),  0);
        check({tag, "_lbp_data"},  int'(bus.lbp_data),  0);
        check({tag, "_busy"},      int'(bus.busy),      0);
        check({tag, "_finish"},    int'(bus.finish),    0);
    endtask

    // One frame: start pulse, optional gray_ready delay, optional start while busy
    task automatic run_frame(input int thr, input int wb, input int rdy_delay, input int mid_start);
        int n;
        int req_seen;
        @(posedge clk); #1;
        bus.thr = 8'(thr);
        bus.write_border = wb[0];
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.thr = 8'hC8;
        bus.write_border = ~wb[0];
        check("busy_after_start", int'(bus.busy), 1);
        check("finish_cleared", int'(bus.finish), 0);
        req_seen = 0;
        for (int i = 0; i < rdy_delay; i++) begin
            @(posedge clk); #1;
            if (bus.gray_req) req_seen = 1;
        end
        if (rdy_delay > 0) check("no_req_while_not_ready", req_seen, 0);
        bus.gray_ready = 1'b1;
        n = 0;
        while (!bus.finish && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (mid_start != 0 && n == 10) bus.start = 1'b1;
            if (n == 11) bus.start = 1'b0;
        end
        check("frame_latency", n - 1, 57);
        check("busy_after_done", int'(bus.busy), 0);
        check("writes_outstanding", exp_q.size(), 0);
        bus.gray_ready = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.thr = '0;
        bus.write_border = 1'b0;
        bus.gray_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'd50;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs_zero("reset");

        // Flat image, thr=0, ready delayed 20 cycles
        push_int(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_frame(0, 0, 20, 0);
        // Flat image, thr=1, second start while busy must be ignored
        push_int(8'h00, 8'h00, 8'h00, 8'h00);
        run_frame(1, 0, 0, 1);
        // Flat image with border writes
        for (int a = 0; a < 16; a++)
            push(a, (a == 5 || a == 6 || a == 9 || a == 10) ? 8'hFF : 8'h00);
        run_frame(0, 1, 0, 0);
        // Pixel value = address
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        push_int(8'hF0, 8'hF0, 8'hF0, 8'hF0);
        run_frame(0, 0, 3, 0);
        // Saturation: centre 250 among 255s
        for (int i = 0; i < 16; i++) mem[i] = 8'd255;
        mem[5] = 8'd250;
        push_int(8'h00, 8'h00, 8'h00, 8'h00);
        run_frame(10, 0, 0, 0);
        push_int(8'hFF, 8'h00, 8'h00, 8'h00);
        run_frame(5, 0, 0, 0);

        // Abort a frame with reset while fetching
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        @(posedge clk); #1;
        bus.thr = 8'd0;
        bus.write_border = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.gray_ready = 1'b1;
        n = 0;
        while (!bus.gray_req && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("fetch_reached", int'(bus.gray_req), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        bus.gray_ready = 1'b0;

        // Clean frame after the abort
        push_int(8'hF0, 8'hF0, 8'hF0, 8'hF0);
        run_frame(0, 0, 0, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lbp_engine.md
# lbp_engine

Parametrised local-binary-pattern engine for the image-processing path. It scans a W×H grayscale image held in an external synchronous-read memory, and computes an 8-bit LBP code for every interior pixel against a programmable threshold. It writes each code to the result memory, optionally writes zero codes for border pixels, and raises a sticky finish flag when the frame is done. Image size and pixel width are build-time parameters; threshold and border mode are run-time inputs.

## Interface
- W_LOG2, 7, log2 of image width (≥2)
- H_LOG2, 7, log2 of image height (≥2)
- PIX_W, 8, gray pixel width in bits
- ADDR_W (derived, W_LOG2+H_LOG2), address width; address = {y, x}
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle frame start; honoured only when busy=0
- thr  in  PIX_W  comparison offset, sampled on accepted start
- write_border  in  1  1 = emit code 0 for border pixels; sampled on accepted start
- gray_ready  in  1  image memory loaded and readable
- gray_req  out  1  read strobe
- gray_addr  out  ADDR_W  read address
- gray_data  in  PIX_W  read data, valid the cycle after gray_req
- lbp_valid  out  1  result write strobe, one cycle per write
- lbp_addr  out  ADDR_W  result address
- lbp_data  out  8  LBP code
- busy  out  1  frame in progress
- finish  out  1  sticky frame-complete flag, cleared by next accepted start

## Operation
- States: IDLE, WAIT_RDY, PIXEL, FETCH, LAST, WRITE, DONE.
- IDLE: start=1 → latch thr/write_border, clear finish, x=y=0, busy=1 → WAIT_RDY.
- WAIT_RDY: hold until gray_ready=1 → PIXEL.
- Scan order is raster: x fastest, 0..W-1, then y 0..H-1.
- PIXEL, border pixel (x=0, x=W-1, y=0 or y=H-1):
  - 1 cycle.
  - If write_border=1, registered write of lbp_addr={y,x}, lbp_data=0, lbp_valid=1.
  - Then advance.
- PIXEL, interior pixel → FETCH.
- FETCH:
  - 9 cycles, gray_req=1, issuing addresses in this order: center, lu, up, ru, left, right, dl, down, dr.
  - Neighbour k (0..7 in that order) drives code bit k.
- Data capture:
  - Data returning the cycle after the center request is latched as C.
  - Each neighbour N sets bit k iff N ≥ C + thr.
  - Sum is computed in PIX_W+1 bits, so C + thr above the max pixel value yields bit 0; no wrap.
- LAST: 1 cycle with gray_req=0; captures the dr data.
- WRITE: 1 cycle, lbp_valid=1, lbp_addr={y,x}, lbp_data=code; code register clears; advance.
- Advance:
  - x+1; at x=W-1, x=0 and y+1.
  - After pixel (W-1,H-1) → DONE.
- DONE: busy=0, finish=1 (sticky) → IDLE.
- start while busy=1 is ignored.
- gray_ready is checked only in WAIT_RDY; a drop mid-frame is not observed.

## Timing
- Reset values: gray_req=0, gray_addr=0, lbp_valid=0, lbp_addr=0, lbp_data=0, busy=0, finish=0; state=IDLE.
- Reset mid-frame aborts immediately; no partial write is completed.
- gray_addr and gray_req are registered; memory returns data one cycle after the request.
- Cost per pixel:
  - Interior pixel: 11 cycles (1 PIXEL + 9 FETCH + 1 LAST ... WRITE overlaps as the 11th cycle).
  - Border pixel: 1 cycle.
- Frame latency from gray_ready seen to finish=1 is 11·(W-2)(H-2) + 2W + 2(H-2) + 1 cycles.
  - 128×128: 174636 + 508 + 1 = 175145.
- lbp_addr/lbp_data are valid only while lbp_valid=1; otherwise they hold their last value.
- Writes are strictly ascending in address.

## Test plan
- 4×4 (W_LOG2=H_LOG2=2), all pixels 50, thr=0, write_border=0 → 4 writes of 0xFF at addresses 5, 6, 9, 10; finish=1 after 57 cycles.
- Same image, thr=1 → 4 writes of 0x00; same addresses and timing.
- Same image, thr=0, write_border=1 → 16 writes at addresses 0..15 in order; border entries 0x00, interior entries 0xFF.
- 4×4 image with pixel = address, thr=0 → address 5 code 0xF0, address 6 0xF0, address 9 0xF0, address 10 0xF0.
- Saturation: center 250, all neighbours 255, thr=10 → code 0x00. The same case with thr=5 → code 0xFF.
- Control cases:
  - gray_ready held low 20 cycles after start → no gray_req until it rises.
  - Second start while busy → ignored.
  - reset asserted during FETCH → all outputs 0 next edge.
  - New start afterwards → frame completes correctly.
